btn_press_decoder: RTL and testbench

BTN_PRESS_DECODER -- requirements
Module: btn_press_decoder

---
 rtl/btn_press_decoder_pkg.sv | 56 +++++
 rtl/btn_press_decoder_sync.sv | 27 ++
 rtl/btn_press_decoder.sv | 130 +++++++++++++
 tb/tb_btn_press_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_press_decoder_pkg.sv
// Shared constants, glyph table and state enumeration for the button press decoder.
package btn_press_decoder_pkg;

  localparam int NBTN = 5;

  // Button codes; bit i of the synchronized vector maps to code i+1.
  localparam logic [2:0] CODE_NONE  = 3'd0;
  localparam logic [2:0] CODE_R     = 3'd1;
  localparam logic [2:0] CODE_M     = 3'd2;
  localparam logic [2:0] CODE_L     = 3'd3;
  localparam logic [2:0] CODE_U     = 3'd4;
  localparam logic [2:0] CODE_D     = 3'd5;
  localparam logic [2:0] CODE_MULTI = 3'd7;

  // Four-digit active-low seven-segment glyphs.
  localparam logic [27:0] GLYPH_UP    = 28'b1000001000110011111111111111;
  localparam logic [27:0] GLYPH_DOWN  = 28'b1000000100000010101011001000;
  localparam logic [27:0] GLYPH_LEFT  = 28'b1000111000011000011100000111;
  localparam logic [27:0] GLYPH_RITE  = 28'b1001100111100100001110000110;
  localparam logic [27:0] GLYPH_MID   = 28'b1101010111100110000001111111;
  localparam logic [27:0] GLYPH_BLANK = 28'hFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  // True when exactly one button is down.
  function automatic logic is_single(input logic [NBTN-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Code of the lowest set button; only meaningful for a single-button vector.
  function automatic logic [2:0] code_of(input logic [NBTN-1:0] v);
    if (v[0])      return CODE_R;
    else if (v[1]) return CODE_M;
    else if (v[2]) return CODE_L;
    else if (v[3]) return CODE_U;
    else if (v[4]) return CODE_D;
    else           return CODE_NONE;
  endfunction

  function automatic logic [27:0] glyph_of(input logic [2:0] code);
    case (code)
      CODE_R:  return GLYPH_RITE;
      CODE_M:  return GLYPH_MID;
      CODE_L:  return GLYPH_LEFT;
      CODE_U:  return GLYPH_UP;
      CODE_D:  return GLYPH_DOWN;
      default: return GLYPH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/btn_press_decoder_sync.sv
// Two-flop synchronizer for the five raw push-button inputs.
module btn_sync
  import btn_press_decoder_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] din,
  output logic [NBTN-1:0] dout
);

  logic [NBTN-1:0] sync_p0;
  logic [NBTN-1:0] sync_p1;

  // Metastability filter: two back-to-back flops per button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  assign dout = sync_p1;

endmodule

// File: rtl/btn_press_decoder.sv
// Debounces five push buttons and reports one event per physical press.
module btn_press_decoder
  import btn_press_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btnR,
  input  logic        btnM,
  input  logic        btnL,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        enable,
  input  logic        clr_count,
  output logic        press_valid,
  output logic [2:0]  press_code,
  output logic [27:0] press_glyph,
  output logic        multi_err,
  output logic        held,
  output logic [5:0]  press_count
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [NBTN-1:0] v;
  state_t          state, state_n;
  logic [NBTN-1:0] cap, cap_n;
  logic [7:0]      cnt, cnt_n;
  logic            fire;
  logic            pv_n, me_n, held_n;
  logic [2:0]      code_n;
  logic [27:0]     glyph_n;
  logic [5:0]      count_n;

  btn_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  ({btnD, btnU, btnL, btnM, btnR}),
    .dout (v)
  );

  // Next-state logic and the registered-output values for the coming edge.
  always_comb begin
    state_n = state;
    cap_n   = cap;
    cnt_n   = cnt;
    fire    = 1'b0;
    if (!enable) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (v != '0) begin
            cap_n   = v;
            cnt_n   = '0;
            state_n = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (v == '0) begin
            state_n = ST_IDLE;
          end else if (v != cap) begin
            cap_n = v;
            cnt_n = '0;
          end else if (cnt == CNT_LAST) begin
            state_n = ST_HELD;
            fire    = 1'b1;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        ST_HELD: begin
          if (v == '0) begin
            cnt_n   = '0;
            state_n = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (v != '0) begin
            state_n = ST_HELD;
          end else if (cnt == CNT_LAST) begin
            state_n = ST_IDLE;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    pv_n    = fire && is_single(cap);
    me_n    = fire && !is_single(cap);
    code_n  = pv_n ? code_of(cap) : (me_n ? CODE_MULTI : CODE_NONE);
    glyph_n = pv_n ? glyph_of(code_n) : GLYPH_BLANK;
    held_n  = (state_n == ST_HELD) || (state_n == ST_RELEASE);

    // A clear takes priority over a coinciding increment.
    if (clr_count)  count_n = '0;
    else if (pv_n)  count_n = press_count + 6'd1;
    else            count_n = press_count;
  end

  // State, debounce bookkeeping and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cap         <= '0;
      cnt         <= '0;
      press_valid <= 1'b0;
      multi_err   <= 1'b0;
      press_code  <= CODE_NONE;
      press_glyph <= GLYPH_BLANK;
      held        <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_n;
      cap         <= cap_n;
      cnt         <= cnt_n;
      press_valid <= pv_n;
      multi_err   <= me_n;
      press_code  <= code_n;
      press_glyph <= glyph_n;
      held        <= held_n;
      press_count <= count_n;
    end
  end

endmodule

// File: tb/tb_btn_press_decoder.sv
// Scoreboard bench for btn_press_decoder: run-length reference model plus monitor.
module tb_btn_press_decoder;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        clr_count = 1'b0;
  logic [4:0]  raw = '0;
  wire         btnR = raw[0];
  wire         btnM = raw[1];
  wire         btnL = raw[2];
  wire         btnU = raw[3];
  wire         btnD = raw[4];
  logic        press_valid, multi_err, held;
  logic [2:0]  press_code;
  logic [27:0] press_glyph;
  logic [5:0]  press_count;

  always #5 clk = ~clk;

  btn_press_decoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .btnR        (btnR),
    .btnM        (btnM),
    .btnL        (btnL),
    .btnU        (btnU),
    .btnD        (btnD),
    .enable      (enable),
    .clr_count   (clr_count),
    .press_valid (press_valid),
    .press_code  (press_code),
    .press_glyph (press_glyph),
    .multi_err   (multi_err),
    .held        (held),
    .press_count (press_count)
  );

  typedef struct {
    int          cyc;
    bit          single;
    logic [2:0]  code;
    logic [27:0] glyph;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  exp_held = 0;
  int  exp_count = 0;

  function automatic logic [27:0] glyph_for(input int idx);
    case (idx)
      0: return 28'b1001100111100100001110000110;
      1: return 28'b1101010111100110000001111111;
      2: return 28'b1000111000011000011100000111;
      3: return 28'b1000001000110011111111111111;
      4: return 28'b1000000100000010101011001000;
      default: return 28'hFFF_FFFF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, expv);
    end
  endtask

  // Reference model: the synchronized vector must repeat the same non-zero
  // value for D+1 enabled samples to produce an event; afterwards it must
  // read zero for D+1 consecutive samples before a new press can count.
  initial begin : model
    logic [4:0] s1, s2, v, cap;
    int run, zrun, idx;
    bit latched, fire, single;
    s1 = '0; s2 = '0; cap = '0; run = 0; zrun = 0; latched = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        s1 = '0; s2 = '0; cap = '0; run = 0; zrun = 0; latched = 0;
        exp_count = 0;
      end else begin
        v  = s2;
        s2 = s1;
        s1 = raw;
        fire = 0;
        if (!enable) begin
          latched = 0;
          run = 0;
        end else if (!latched) begin
          if (v == 0) run = 0;
          else if (run > 0 && v == cap) run++;
          else begin
            cap = v;
            run = 1;
          end
          if (run == D + 1) begin
            fire = 1; latched = 1; zrun = 0; run = 0;
          end
        end else begin
          if (v == 0) zrun++;
          else zrun = 0;
          if (zrun == D + 1) begin
            latched = 0; run = 0;
          end
        end
        single = ($countones(cap) == 1);
        if (fire) begin
          ev_t e;
          e.cyc = cyc;
          e.single = single;
          idx = 0;
          for (int i = 0; i < 5; i++) if (cap[i]) idx = i;
          e.code  = single ? 3'(idx + 1) : 3'd7;
          e.glyph = single ? glyph_for(idx) : 28'hFFF_FFFF;
          exp_q.push_back(e);
        end
        if (clr_count) exp_count = 0;
        else if (fire && single) exp_count = (exp_count + 1) % 64;
      end
      exp_held = latched;
    end
  end

  // Monitor: compare DUT outputs against the scoreboard every falling edge.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("press_valid", 32'(press_valid), 32'(e.single));
        chk("multi_err", 32'(multi_err), 32'(!e.single));
        chk("press_code", 32'(press_code), 32'(e.code));
        chk("press_glyph", 32'(press_glyph), 32'(e.glyph));
      end else begin
        chk("press_valid_idle", 32'(press_valid), 32'd0);
        chk("multi_err_idle", 32'(multi_err), 32'd0);
        chk("press_code_idle", 32'(press_code), 32'd0);
        chk("press_glyph_idle", 32'(press_glyph), 32'hFFF_FFFF);
      end
      chk("held", 32'(held), 32'(exp_held));
      chk("press_count", 32'(press_count), 32'(exp_count));
    end
  end

  task automatic hold(input logic [4:0] b, input int n);
    raw = b;
    repeat (n) @(negedge clk);
  endtask

  // Stimulus: directed scenarios first, then randomized presses.
  initial begin : stim
    int n;
    logic [4:0] m;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(5'b00000, 3);
    hold(5'b01000, 20);  hold(5'b00000, 12);                     // clean U
    for (int i = 0; i < 3; i++) begin                           // bouncing L
      hold(5'b00100, 2); hold(5'b00000, 1);
    end
    hold(5'b00100, 12);  hold(5'b00000, 12);
    hold(5'b10001, 10);  hold(5'b00000, 12);                     // R+D together
    hold(5'b00010, 10);  hold(5'b00000, 2);                      // M short gap
    hold(5'b00010, 10);  hold(5'b00000, 12);
    hold(5'b00010, 10);  hold(5'b00000, 6);                      // M long gap
    hold(5'b00010, 10);  hold(5'b00000, 12);
    for (int i = 0; i < 64; i++) begin                          // count wrap
      hold(5'b10000, 8); hold(5'b00000, 8);
    end
    hold(5'b10000, 6);                                          // clear on pulse
    clr_count = 1'b1; @(negedge clk); clr_count = 1'b0;
    hold(5'b10000, 6);   hold(5'b00000, 12);
    hold(5'b00010, 5);                                          // reset mid-debounce
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    hold(5'b00010, 12);  hold(5'b00000, 12);
    hold(5'b01000, 10);                                         // enable drop in HELD
    enable = 1'b0; @(negedge clk); @(negedge clk); enable = 1'b1;
    hold(5'b01000, 12);  hold(5'b00000, 12);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 4) == 0) m = 5'($urandom_range(1, 31));
      else m = 5'(1 << $urandom_range(0, 4));
      n = $urandom_range(1, 12);
      raw = m;
      for (int c = 0; c < n; c++) begin
        enable    = ($urandom_range(0, 29) != 0);
        clr_count = ($urandom_range(0, 24) == 0);
        rst       = ($urandom_range(0, 199) == 0);
        @(negedge clk);
      end
      enable = 1'b1; clr_count = 1'b0; rst = 1'b0;
      hold(5'b00000, $urandom_range(1, 9));
    end
    hold(5'b00000, 15);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
